// File: rtl/inert_spi_slave_if.sv
// SPI pin bundle for the inertial sensor link.
// The master modport is the host side and the slave modport is the sensor side.
interface inert_spi_slave_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS_n, output SCLK, output MOSI, input MISO);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/inert_spi_slave.sv
// Inertial-sensor SPI responder on a 16-bit mode-3 link.
// It takes config writes, answers register reads, and issues periodic ptch/AZ samples with INT.
module inert_spi_slave #(
    parameter logic [15:0] MEAS_PERIOD = 16'd2048,
    parameter logic [7:0]  WHO_AM_I    = 8'h6A
) (
    input  logic               clk,
    input  logic               rst,
    inert_spi_slave_if.slave   spi,
    output logic               INT,
    input  logic [15:0]        ptch_in,
    input  logic [15:0]        AZ_in,
    output logic               cfg_ok
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [15:0] LAST_CNT = MEAS_PERIOD - 16'd1;

    logic [2:0]  ss_sync, sclk_sync, mosi_sync;
    logic        ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_s;
    state_t      state;
    logic [4:0]  bit_cnt;
    logic [7:0]  rx;
    logic [15:0] tx;
    logic [7:0]  cmd;
    logic        miso_q;
    logic [7:0]  reg_0d, reg_10, reg_11, reg_14;
    logic [15:0] ptch_q, az_q;
    logic [15:0] period_cnt;
    logic        pending;
    logic [6:0]  rd_addr;
    logic [7:0]  rd_byte;
    logic        commit, int_clr, meas_en, update;

    // Two flops for metastability, then a third to provide the previous value for edge detection.
    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_sync   <= 3'b111;
            sclk_sync <= 3'b111;
            mosi_sync <= 3'b000;
        end else begin
            ss_sync   <= {ss_sync[1:0], spi.SS_n};
            sclk_sync <= {sclk_sync[1:0], spi.SCLK};
            mosi_sync <= {mosi_sync[1:0], spi.MOSI};
        end
    end

    assign ss_fall   = ss_sync[2] & ~ss_sync[1];
    assign ss_rise   = ~ss_sync[2] & ss_sync[1];
    assign sclk_rise = ~sclk_sync[2] & sclk_sync[1];
    assign sclk_fall = sclk_sync[2] & ~sclk_sync[1];
    assign mosi_s    = mosi_sync[2];

    // Register address seen on the 8th rising edge, before rx has absorbed that bit.
    assign rd_addr = {rx[5:0], mosi_s};

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        rd_byte = 8'h00;
        case (rd_addr)
            7'h0D:   rd_byte = reg_0d;
            7'h0F:   rd_byte = WHO_AM_I;
            7'h10:   rd_byte = reg_10;
            7'h11:   rd_byte = reg_11;
            7'h14:   rd_byte = reg_14;
            7'h22:   rd_byte = ptch_q[7:0];
            7'h23:   rd_byte = ptch_q[15:8];
            7'h2C:   rd_byte = az_q[7:0];
            7'h2D:   rd_byte = az_q[15:8];
            default: rd_byte = 8'h00;
        endcase
    end

    assign commit  = (state == DONE) && (bit_cnt == 5'd16);
    assign int_clr = commit && (cmd == 8'hA2);

    // NOTE: the small register file is built from discrete flops, so it can be cleared by reset like any other state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= 5'd0;
            rx      <= 8'h00;
            tx      <= 16'h0000;
            cmd     <= 8'h00;
            miso_q  <= 1'b0;
            reg_0d  <= 8'h00;
            reg_10  <= 8'h00;
            reg_11  <= 8'h00;
            reg_14  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    miso_q <= 1'b0;
                    if (ss_fall) begin
                        state   <= SHIFT;
                        bit_cnt <= 5'd0;
                        tx      <= 16'h0000;
                    end
                end
                SHIFT: begin
                    if (ss_rise) begin
                        state <= DONE;
                    end else begin
                        if (sclk_rise) begin
                            rx <= {rx[6:0], mosi_s};
                            if (bit_cnt != 5'd16) bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                cmd <= {rx[6:0], mosi_s};
                                // Eight falls are still to come, so the read byte goes into the top of tx.
                                if (rx[6]) tx <= {rd_byte, 8'h00};
                            end
                        end
                        if (sclk_fall) begin
                            miso_q <= tx[15];
                            tx     <= {tx[14:0], 1'b0};
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    miso_q <= 1'b0;
                    if (commit && !cmd[7]) begin
                        case (cmd[6:0])
                            7'h0D:   reg_0d <= rx;
                            7'h10:   reg_10 <= rx;
                            7'h11:   reg_11 <= rx;
                            7'h14:   reg_14 <= rx;
                            default: ;
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign spi.MISO = miso_q;
    assign cfg_ok   = (reg_0d == 8'h02) && (reg_10 == 8'h53) &&
                      (reg_11 == 8'h50) && (reg_14 == 8'h60);

    // Samples land only while no frame is in flight, so a read never mixes old and new bytes.
    assign meas_en = (reg_0d == 8'h02);
    assign update  = pending && ss_sync[1] && (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_cnt <= 16'd0;
            pending    <= 1'b0;
            INT        <= 1'b0;
            ptch_q     <= 16'h0000;
            az_q       <= 16'h0000;
        end else if (!meas_en) begin
            period_cnt <= 16'd0;
            pending    <= 1'b0;
            INT        <= 1'b0;
        end else begin
            period_cnt <= (period_cnt == LAST_CNT) ? 16'd0 : period_cnt + 16'd1;
            if (int_clr) INT <= 1'b0;
            if (update) begin
                ptch_q  <= ptch_in;
                az_q    <= AZ_in;
                INT     <= 1'b1;
                pending <= 1'b0;
            end
            if (period_cnt == LAST_CNT) pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_inert_spi_slave.sv
// Randomized bench for inert_spi_slave against a register-map model of the sensor.
// The host drives mode-3 frames, and the model supplies every expected read, cfg_ok and INT value.
module tb_inert_spi_slave;

    localparam int P    = 512;
    localparam int HALF = 8;
    localparam int GAP  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        INT, cfg_ok;
    logic [15:0] ptch_in, AZ_in;
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    int          last_rise = 0;

    logic [7:0]  m_rw [logic [6:0]];
    logic [15:0] m_ptch, m_az;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    inert_spi_slave_if bus ();

    inert_spi_slave #(.MEAS_PERIOD(16'(P))) dut (
        .clk     (clk),
        .rst     (rst),
        .spi     (bus.slave),
        .INT     (INT),
        .ptch_in (ptch_in),
        .AZ_in   (AZ_in),
        .cfg_ok  (cfg_ok)
    );

    function automatic bit is_rw(input logic [6:0] a);
        return a inside {7'h0D, 7'h10, 7'h11, 7'h14};
    endfunction

    function automatic logic [7:0] model_read(input logic [6:0] a);
        case (a)
            7'h0F: return 8'h6A;
            7'h22: return m_ptch[7:0];
            7'h23: return m_ptch[15:8];
            7'h2C: return m_az[7:0];
            7'h2D: return m_az[15:8];
            default: return m_rw.exists(a) ? m_rw[a] : 8'h00;
        endcase
    endfunction

    function automatic logic model_cfg();
        return model_read(7'h0D) == 8'h02 && model_read(7'h10) == 8'h53 &&
               model_read(7'h11) == 8'h50 && model_read(7'h14) == 8'h60;
    endfunction

    task automatic model_reset();
        m_rw.delete();
        m_ptch = 16'h0000;
        m_az   = 16'h0000;
    endtask

    task automatic spi_begin();
        @(negedge clk);
        bus.SS_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic spi_shift(input logic [15:0] w, input int n, output logic [15:0] r);
        r = 16'h0000;
        for (int i = 0; i < n; i++) begin
            bus.SCLK = 1'b0;
            bus.MOSI = w[15-i];
            repeat (HALF) @(negedge clk);
            r[15-i]  = bus.MISO;
            bus.SCLK = 1'b1;
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic spi_end(input int gap);
        bus.SS_n  = 1'b1;
        last_rise = cyc;
        repeat (gap) @(negedge clk);
    endtask

    task automatic spi_xfer(input logic [15:0] w, output logic [15:0] r);
        spi_begin();
        spi_shift(w, 16, r);
        spi_end(GAP);
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] d);
        logic [15:0] r;
        spi_xfer({1'b0, a, d}, r);
        if (is_rw(a)) m_rw[a] = d;
    endtask

    task automatic check_read(input logic [6:0] a);
        logic [15:0] r;
        logic [15:0] exp;
        exp = {8'h00, model_read(a)};
        spi_xfer({1'b1, a, 8'h00}, r);
        tests++;
        if (r !== exp) begin
            $display("FAIL read_%h: got %h expected %h", a, r, exp);
            fails++;
        end
    endtask

    task automatic wait_int(input int budget, output int when);
        when = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (INT === 1'b1) begin
                when = cyc;
                break;
            end
        end
        tests++;
        if (when < 0) begin
            $display("FAIL int_timeout: INT still %b after %0d clk, expected 1", INT, budget);
            fails++;
        end
    endtask

    // Reads 0x22 until INT is low, in case a deferred update landed just after a clear.
    task automatic clear_int();
        for (int k = 0; k < 3; k++) begin
            check_read(7'h22);
            if (INT === 1'b0) break;
        end
        tests++;
        if (INT !== 1'b0) begin
            $display("FAIL int_clear: INT=%b expected 0", INT);
            fails++;
        end
    endtask

    task automatic test_reset();
        bus.SS_n = 1'b1; bus.SCLK = 1'b1; bus.MOSI = 1'b0;
        ptch_in = 16'h0000; AZ_in = 16'h0000;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        model_reset();
        tests += 3;
        if (bus.MISO !== 1'b0) begin $display("FAIL reset_miso: got %b expected 0", bus.MISO); fails++; end
        if (INT !== 1'b0)      begin $display("FAIL reset_int: got %b expected 0", INT); fails++; end
        if (cfg_ok !== 1'b0)   begin $display("FAIL reset_cfg_ok: got %b expected 0", cfg_ok); fails++; end
    endtask

    task automatic test_who_am_i();
        check_read(7'h0F);
        tests++;
        if (bus.MISO !== 1'b0) begin $display("FAIL miso_idle: got %b expected 0", bus.MISO); fails++; end
        check_read(7'h33);
    endtask

    task automatic test_rw_random();
        logic [6:0] addrs [8] = '{7'h0D, 7'h10, 7'h11, 7'h14, 7'h0F, 7'h22, 7'h2D, 7'h00};
        logic [6:0] a;
        logic [7:0] d;
        for (int i = 0; i < 12; i++) begin
            a = addrs[$urandom_range(7)];
            if (a == 7'h00) a = 7'($urandom);
            d = 8'($urandom);
            if (a == 7'h0D && d == 8'h02) d = 8'h03;
            do_write(a, d);
            tests++;
            if (cfg_ok !== model_cfg()) begin
                $display("FAIL cfg_rand_%0d: got %b expected %b", i, cfg_ok, model_cfg());
                fails++;
            end
        end
        check_read(7'h0D);
        check_read(7'h10);
        check_read(7'h11);
        check_read(7'h14);
        check_read(7'h2D);
    endtask

    task automatic test_cfg_ok();
        logic [15:0] seq [5] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460, 16'h1000};
        logic        exp [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            do_write(seq[i][14:8], seq[i][7:0]);
            tests++;
            if (cfg_ok !== exp[i]) begin
                $display("FAIL cfg_seq_%0d: got %b expected %b", i, cfg_ok, exp[i]);
                fails++;
            end
        end
    endtask

    task automatic test_measure();
        int t, lat;
        logic [15:0] r;
        do_write(7'h0D, 8'h00);
        tests++;
        if (INT !== 1'b0) begin $display("FAIL int_disabled: got %b expected 0", INT); fails++; end
        ptch_in = 16'h1234; AZ_in = 16'hABCD;
        spi_begin();
        spi_shift(16'h0D02, 16, r);
        spi_end(0);
        m_rw[7'h0D] = 8'h02;
        wait_int(2 * P, t);
        lat = t - last_rise;
        tests++;
        if (lat < P || lat > P + 8) begin
            $display("FAIL int_latency: got %0d clk expected %0d..%0d", lat, P, P + 8);
            fails++;
        end
        m_ptch = ptch_in; m_az = AZ_in;
        check_read(7'h22);
        tests++;
        if (INT !== 1'b0) begin $display("FAIL int_fall_a2: got %b expected 0", INT); fails++; end
        check_read(7'h23);
        check_read(7'h2C);
        check_read(7'h2D);
        for (int it = 0; it < 2; it++) begin
            clear_int();
            ptch_in = 16'($urandom); AZ_in = 16'($urandom);
            wait_int(2 * P, t);
            m_ptch = ptch_in; m_az = AZ_in;
            check_read(7'h22);
            check_read(7'h23);
            check_read(7'h2C);
            check_read(7'h2D);
        end
    endtask

    task automatic test_deferred_and_abort();
        int t_int, t, lat, target;
        logic [15:0] r;
        logic [15:0] exp;
        clear_int();
        ptch_in = 16'($urandom); AZ_in = 16'($urandom);
        wait_int(2 * P, t_int);
        m_ptch = ptch_in; m_az = AZ_in;
        check_read(7'h22);
        tests++;
        if (INT !== 1'b0) begin $display("FAIL int_pre_defer: got %b expected 0", INT); fails++; end
        ptch_in = ~m_ptch; AZ_in = ~m_az;
        exp = {8'h00, m_ptch[15:8]};
        target = t_int + P + 40;
        spi_begin();
        spi_shift(16'hA300, 16, r);
        while (cyc < target) @(negedge clk);
        tests += 2;
        if (INT !== 1'b0) begin $display("FAIL int_held_in_frame: got %b expected 0", INT); fails++; end
        if (r !== exp)    begin $display("FAIL defer_read: got %h expected %h", r, exp); fails++; end
        spi_end(0);
        wait_int(20, t);
        lat = t - last_rise;
        tests++;
        if (lat < 2 || lat > 10) begin
            $display("FAIL defer_latency: got %0d clk expected 2..10", lat);
            fails++;
        end
        m_ptch = ptch_in; m_az = AZ_in;
        spi_begin();
        spi_shift(16'h0D00, 9, r);
        spi_end(GAP);
        tests += 2;
        if (INT !== 1'b1)      begin $display("FAIL abort_int: got %b expected 1", INT); fails++; end
        if (bus.MISO !== 1'b0) begin $display("FAIL abort_miso: got %b expected 0", bus.MISO); fails++; end
        check_read(7'h0D);
        check_read(7'h23);
        check_read(7'h2C);
    endtask

    task automatic test_rst_mid_frame();
        logic [15:0] r;
        spi_begin();
        spi_shift(16'hA200, 5, r);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        bus.SCLK = 1'b1;
        spi_end(GAP);
        model_reset();
        check_read(7'h22);
        check_read(7'h0D);
        tests += 2;
        if (INT !== 1'b0)    begin $display("FAIL rst_int: got %b expected 0", INT); fails++; end
        if (cfg_ok !== 1'b0) begin $display("FAIL rst_cfg_ok: got %b expected 0", cfg_ok); fails++; end
    endtask

    initial begin
        test_reset();
        test_who_am_i();
        test_rw_random();
        test_cfg_ok();
        test_measure();
        test_deferred_and_abort();
        test_rst_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
